// File: rtl/div_pkg.sv
// Shared types and sizing for the radix-2 restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage : div_pkg

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate over a bundle of lanes: abs() on operand
// entry, sign restore on result exit.
module div_sign_fix import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH,
   parameter int LANES = 2
) (
   input  logic [LANES-1:0][WIDTH-1:0] val,
   input  logic [LANES-1:0]            neg,
   output logic [LANES-1:0][WIDTH-1:0] res
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign res[gi] = neg[gi] ? (~val[gi] + WIDTH'(1)) : val[gi];
      end
   endgenerate

endmodule : div_sign_fix

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result {rem, quo} lands directly on HI/LO.
module div_radix2 import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]   rem_reg, rem_next;
   logic [WIDTH-1:0]   quo_reg, quo_next;
   logic [WIDTH-1:0]   divisor_reg, divisor_next;
   logic               neg_q_reg, neg_q_next;
   logic               neg_r_reg, neg_r_next;
   logic [2*WIDTH-1:0] result_reg, result_next;

   // Operand magnitudes; lane 0 = dividend, lane 1 = divisor.
   logic                  a_neg, b_neg;
   logic [1:0][WIDTH-1:0] op_val, op_mag;
   logic [1:0]            op_neg;

   assign a_neg  = signed_div_i & a[WIDTH-1];
   assign b_neg  = signed_div_i & b[WIDTH-1];
   assign op_val = {b, a};
   assign op_neg = {b_neg, a_neg};

   div_sign_fix #(.WIDTH(WIDTH), .LANES(2)) u_operand_fix (
      .val (op_val),
      .neg (op_neg),
      .res (op_mag)
   );

   // The shifted partial remainder carries one extra bit so the trial
   // subtract is decided by a full-width compare and never overflows.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_trial, step_rem, step_quo;
   logic             fits;

   assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
   assign fits      = rem_shift >= {1'b0, divisor_reg};
   assign rem_trial = rem_shift[WIDTH-1:0] - divisor_reg;
   assign step_rem  = fits ? rem_trial : rem_shift[WIDTH-1:0];
   assign step_quo  = {quo_reg[WIDTH-2:0], fits};

   logic [1:0][WIDTH-1:0] res_val, res_fix;
   logic [1:0]            res_neg;

   assign res_val = {step_rem, step_quo};
   assign res_neg = {neg_r_reg, neg_q_reg};

   div_sign_fix #(.WIDTH(WIDTH), .LANES(2)) u_result_fix (
      .val (res_val),
      .neg (res_neg),
      .res (res_fix)
   );

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      rem_next     = rem_reg;
      quo_next     = quo_reg;
      divisor_next = divisor_reg;
      neg_q_next   = neg_q_reg;
      neg_r_next   = neg_r_reg;
      result_next  = result_reg;

      if (annul_i) begin
         state_next = DIV_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            DIV_IDLE: begin
               if (start_i) begin
                  if (b == '0) begin
                     result_next = '0;
                     state_next  = DIV_DONE;
                  end else begin
                     quo_next     = op_mag[0];
                     divisor_next = op_mag[1];
                     rem_next     = '0;
                     neg_q_next   = a_neg ^ b_neg;
                     neg_r_next   = a_neg;
                     cnt_next     = '0;
                     state_next   = DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               rem_next = step_rem;
               quo_next = step_quo;
               cnt_next = cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_LAST) begin
                  result_next = res_fix;
                  cnt_next    = '0;
                  state_next  = DIV_DONE;
               end
            end
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= DIV_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg     <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         result_reg  <= '0;
      end else begin
         cnt_reg     <= cnt_next;
         rem_reg     <= rem_next;
         quo_reg     <= quo_next;
         divisor_reg <= divisor_next;
         neg_q_reg   <= neg_q_next;
         neg_r_reg   <= neg_r_next;
         result_reg  <= result_next;
      end
   end

   assign ready_o  = (state_reg == DIV_DONE);
   assign result_o = result_reg;

endmodule : div_radix2

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: latency/arith model plus directed literal vectors.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] a_in, b_in;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int check_count = 0;
   int error_count = 0;

   div_radix2 #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .a            (a_in),
      .b            (b_in),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: plain 64-bit truncating division, {rem, quo}; divide-by-zero gives 0.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      if (y == 32'd0) return 64'd0;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({32'd0, x});
         sy = longint'({32'd0, y});
      end
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   // Behavioural model: a request accepted while idle reports 33 edges later
   // (1 for b==0); annul drops it; ready lasts a single cycle.
   logic        m_busy = 1'b0;
   int          m_left = 0;
   logic [63:0] m_value = '0;
   logic        exp_ready = 1'b0;
   logic [63:0] exp_result = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy     <= 1'b0;
         m_left     <= 0;
         exp_ready  <= 1'b0;
         exp_result <= '0;
      end else if (annul_i) begin
         m_busy    <= 1'b0;
         exp_ready <= 1'b0;
      end else if (exp_ready) begin
         exp_ready <= 1'b0;
      end else if (m_busy) begin
         if (m_left == 1) begin
            m_busy     <= 1'b0;
            exp_ready  <= 1'b1;
            exp_result <= m_value;
         end
         m_left <= m_left - 1;
      end else if (start_i) begin
         if (b_in == 32'd0) begin
            exp_ready  <= 1'b1;
            exp_result <= '0;
         end else begin
            m_busy  <= 1'b1;
            m_left  <= 32;
            m_value <= ref_div(signed_div_i, a_in, b_in);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("model_ready", 64'(ready_o), 64'(exp_ready));
         check("model_result", result_o, exp_result);
      end
   end

   task automatic run_div(input string name, input logic sgn, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input int exp_lat);
      int n;
      @(negedge clk);
      signed_div_i = sgn;
      a_in         = x;
      b_in         = y;
      start_i      = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      a_in    = $urandom;
      b_in    = $urandom;
      n       = 1;
      while (!ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, 64'(ready_o), 64'd1);
      check({name, "_latency"}, 64'(n), 64'(exp_lat));
      check({name, "_result"}, result_o, exp);
      $display("op %s sgn=%0b a=%h b=%h -> result=%h latency=%0d", name, sgn, x, y, result_o, n);
      @(negedge clk);
      check({name, "_pulse"}, 64'(ready_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      int got;
      int cyc;
      rst          = 1'b0;
      signed_div_i = 1'b0;
      a_in         = '0;
      b_in         = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_result", result_o, 64'd0);
      check("reset_ready", 64'(ready_o), 64'd0);
      #2 rst = 1'b1;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
      check("model_pin_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
      check("model_pin_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
      run_div("div_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
      check("model_pin_minneg", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
      run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
      run_div("div_by_zero", 1'b1, 32'd1234, 32'd0, 64'd0, 1);
      run_div("divu_7_100", 1'b0, 32'd7, 32'd100, {32'd7, 32'd0}, 33);
      run_div("divu_100_7b", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

      // Annul mid-run: no ready, result held.
      @(negedge clk);
      signed_div_i = 1'b0;
      a_in         = 32'hFFFF_FFFF;
      b_in         = 32'd1;
      start_i      = 1'b1;
      seen         = 0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         start_i = 1'b0;
         annul_i = (i == 10);
         if (ready_o) seen++;
      end
      annul_i = 1'b0;
      check("annul_no_ready", 64'(seen), 64'd0);
      check("annul_hold", result_o, {32'd2, 32'd14});
      $display("op annul_mid_run ready_seen=%0d result=%h", seen, result_o);

      // Asynchronous reset mid-run clears the result at once.
      @(negedge clk);
      a_in    = 32'd1000;
      b_in    = 32'd3;
      start_i = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      check("async_reset_result", result_o, 64'd0);
      check("async_reset_ready", 64'(ready_o), 64'd0);
      $display("op async_reset result=%h", result_o);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;

      // Back-to-back with start = valid & ~ready and a mid-run operand change.
      @(negedge clk);
      signed_div_i = 1'b0;
      a_in         = 32'd1000;
      b_in         = 32'd10;
      start_i      = 1'b1;
      got          = 0;
      cyc          = 0;
      while (got < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ready_o) begin
            got++;
            if (got == 1) begin
               check("b2b_first", result_o, {32'd0, 32'd100});
               signed_div_i = 1'b1;
               a_in         = 32'hFFFF_FF9C;
               b_in         = 32'd7;
            end else begin
               check("b2b_second", result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
            end
            $display("op b2b_%0d result=%h cycle=%0d", got, result_o, cyc);
         end
         if (cyc == 10 && got == 0) begin
            a_in = 32'h1234_5678;
            b_in = 32'd3;
         end
         start_i = (got < 2) & ~ready_o;
      end
      start_i = 1'b0;
      check("b2b_count", 64'(got), 64'd2);
      repeat (3) @(negedge clk);
      check("b2b_idle_ready", 64'(ready_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule : tb_div_radix2
